// File: rtl/hazard_stall_if.sv
// Hazard unit bundle: ID/EX/MEM pipeline observations in, stall/flush controls and
// debug counters out. The pipeline side drives the master modport.
interface hazard_stall_if #(
  parameter int NB_REG_ADDR = 5,
  parameter int NB_CNT      = 32
);
  logic                   i_valid;
  logic [NB_REG_ADDR-1:0] i_rs;
  logic [NB_REG_ADDR-1:0] i_rt;
  logic                   i_uses_rt;
  logic                   i_branch;
  logic                   i_jump_taken;
  logic [NB_REG_ADDR-1:0] i_rd_ex;
  logic                   i_we_ex;
  logic                   i_memread_ex;
  logic [NB_REG_ADDR-1:0] i_rd_mem;
  logic                   i_memread_mem;
  logic                   o_stall;
  logic                   o_bubble_idex;
  logic                   o_flush_ifid;
  logic [NB_CNT-1:0]      o_stall_cycles;
  logic [NB_CNT-1:0]      o_flush_count;

  modport master (
    output i_valid, i_rs, i_rt, i_uses_rt, i_branch, i_jump_taken,
           i_rd_ex, i_we_ex, i_memread_ex, i_rd_mem, i_memread_mem,
    input  o_stall, o_bubble_idex, o_flush_ifid, o_stall_cycles, o_flush_count
  );

  modport slave (
    input  i_valid, i_rs, i_rt, i_uses_rt, i_branch, i_jump_taken,
           i_rd_ex, i_we_ex, i_memread_ex, i_rd_mem, i_memread_mem,
    output o_stall, o_bubble_idex, o_flush_ifid, o_stall_cycles, o_flush_count
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// ID-stage hazard detector: stalls PC/IF-ID and bubbles ID/EX for hazards the
// forwarding network cannot cover, flushes IF/ID on taken jumps, and keeps
// saturating debug counters of stalls and flushes.
//
//  state | meaning
//  ------+-----------------------------------------------------------------
//  IDLE  | normal issue; stall only if the current ID instruction needs one
//  EXTRA | second stall cycle of a branch waiting on an EX-stage load
module hazard_stall_unit #(
  parameter int NB_REG_ADDR = 5,
  parameter int NB_CNT      = 32
) (
  input logic           i_clock,
  input logic           i_reset,
  hazard_stall_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, EXTRA = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        match_ex, match_mem;
  logic [1:0]  n_req;
  logic        stall, flush;
  logic [NB_CNT-1:0] stall_cnt_q, flush_cnt_q;

  localparam logic [NB_CNT-1:0] CNT_ONE = {{(NB_CNT-1){1'b0}}, 1'b1};

  // Source/destination matches; register 0 is never a hazard.
  always_comb begin
    match_ex  = ((bus.i_rs == bus.i_rd_ex) | (bus.i_uses_rt & (bus.i_rt == bus.i_rd_ex)))
                & (bus.i_rd_ex != '0);
    match_mem = ((bus.i_rs == bus.i_rd_mem) | (bus.i_uses_rt & (bus.i_rt == bus.i_rd_mem)))
                & (bus.i_rd_mem != '0);
  end

  // Number of stall cycles required by the ID instruction, first matching rule wins.
  always_comb begin
    n_req = 2'd0;
    if (bus.i_branch & match_ex & bus.i_we_ex & bus.i_memread_ex)
      n_req = 2'd2;
    else if (bus.i_branch & match_ex & bus.i_we_ex & ~bus.i_memread_ex)
      n_req = 2'd1;
    else if (~bus.i_branch & match_ex & bus.i_we_ex & bus.i_memread_ex)
      n_req = 2'd1;
    else if (bus.i_branch & match_mem & bus.i_memread_mem)
      n_req = 2'd1;
  end

  // Next state and same-cycle stall/flush decisions.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    flush   = 1'b0;
    case (state_q)
      IDLE: begin
        stall = (n_req != 2'd0);
        // A jump behind a pending hazard is unresolved, so it is not flushed yet.
        flush = (n_req == 2'd0) & bus.i_jump_taken;
        if (n_req == 2'd2) state_d = EXTRA;
      end
      EXTRA: begin
        stall   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; frozen while the pipeline is not advancing.
  always_ff @(posedge i_clock) begin
    if (i_reset)           state_q <= IDLE;
    else if (bus.i_valid)  state_q <= state_d;
  end

  // Saturating debug counters, counted only on advancing cycles.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (bus.i_valid) begin
      if (stall & ~&stall_cnt_q) stall_cnt_q <= stall_cnt_q + CNT_ONE;
      if (flush & ~&flush_cnt_q) flush_cnt_q <= flush_cnt_q + CNT_ONE;
    end
  end

  assign bus.o_stall        = stall;
  assign bus.o_bubble_idex  = stall;
  assign bus.o_flush_ifid   = flush;
  assign bus.o_stall_cycles = stall_cnt_q;
  assign bus.o_flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: directed scenarios with literal expectations, then
// random traffic checked every cycle against a stall-budget model.
module tb_hazard_stall_unit;
  localparam int NA = 5;
  localparam int NC = 6;
  localparam int CMAX = (1 << NC) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  bit   chk_en = 1'b0;

  hazard_stall_if #(.NB_REG_ADDR(NA), .NB_CNT(NC)) bus ();

  hazard_stall_unit #(.NB_REG_ADDR(NA), .NB_CNT(NC)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Model: remaining forced stall cycles owed by an earlier instruction, plus counters.
  int m_pend = 0;
  int m_scnt = 0;
  int m_fcnt = 0;

  function automatic int model_n();
    bit mex, mmem;
    mex  = (bus.i_rd_ex != 0) && (bus.i_rs == bus.i_rd_ex || (bus.i_uses_rt && bus.i_rt == bus.i_rd_ex));
    mmem = (bus.i_rd_mem != 0) && (bus.i_rs == bus.i_rd_mem || (bus.i_uses_rt && bus.i_rt == bus.i_rd_mem));
    if (bus.i_branch && mex && bus.i_we_ex && bus.i_memread_ex)  return 2;
    if (bus.i_branch && mex && bus.i_we_ex && !bus.i_memread_ex) return 1;
    if (!bus.i_branch && mex && bus.i_we_ex && bus.i_memread_ex) return 1;
    if (bus.i_branch && mmem && bus.i_memread_mem)               return 1;
    return 0;
  endfunction

  function automatic bit exp_stall();
    return (m_pend > 0) || (model_n() > 0);
  endfunction

  function automatic bit exp_flush();
    return (m_pend == 0) && (model_n() == 0) && bus.i_jump_taken;
  endfunction

  always @(posedge clk) begin
    bit s, f;
    int n;
    s = exp_stall();
    f = exp_flush();
    n = model_n();
    if (rst) begin
      m_pend = 0; m_scnt = 0; m_fcnt = 0;
    end else if (bus.i_valid) begin
      if (s && m_scnt < CMAX) m_scnt++;
      if (f && m_fcnt < CMAX) m_fcnt++;
      if (m_pend > 0) m_pend--;
      else            m_pend = (n > 0) ? n - 1 : 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_stall",  32'(bus.o_stall),        32'(exp_stall()));
      chk("m_bubble", 32'(bus.o_bubble_idex),  32'(exp_stall()));
      chk("m_flush",  32'(bus.o_flush_ifid),   32'(exp_flush()));
      chk("m_scnt",   32'(bus.o_stall_cycles), 32'(m_scnt));
      chk("m_fcnt",   32'(bus.o_flush_count),  32'(m_fcnt));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    bus.i_valid = 1'b1; bus.i_rs = '0; bus.i_rt = '0; bus.i_uses_rt = 1'b0;
    bus.i_branch = 1'b0; bus.i_jump_taken = 1'b0; bus.i_rd_ex = '0; bus.i_we_ex = 1'b0;
    bus.i_memread_ex = 1'b0; bus.i_rd_mem = '0; bus.i_memread_mem = 1'b0;
  endtask

  task automatic load_in_ex(input int rd);
    bus.i_rd_ex = NA'(rd); bus.i_we_ex = 1'b1; bus.i_memread_ex = 1'b1;
  endtask

  initial begin
    idle_in();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk_en = 1'b1;
    chk("rst_scnt", 32'(bus.o_stall_cycles), 0);
    chk("rst_fcnt", 32'(bus.o_flush_count), 0);
    chk("rst_stall", 32'(bus.o_stall), 0);

    // load-use: one stall
    load_in_ex(5); bus.i_rs = 5; #1;
    chk("lu_stall", 32'(bus.o_stall), 1);
    chk("lu_bubble", 32'(bus.o_bubble_idex), 1);
    tick(); idle_in(); #1;
    chk("lu_clear", 32'(bus.o_stall), 0);
    chk("lu_scnt", 32'(bus.o_stall_cycles), 1);

    // branch on EX load: two stalls even though inputs change
    load_in_ex(3); bus.i_rs = 3; bus.i_branch = 1'b1; #1;
    chk("bl_stall1", 32'(bus.o_stall), 1);
    tick(); idle_in(); #1;
    chk("bl_stall2", 32'(bus.o_stall), 1);
    tick(); #1;
    chk("bl_clear", 32'(bus.o_stall), 0);
    chk("bl_scnt", 32'(bus.o_stall_cycles), 3);

    // branch on EX ALU result via rt: one stall; r0 never hazards
    bus.i_rd_ex = 7; bus.i_we_ex = 1'b1; bus.i_branch = 1'b1; bus.i_uses_rt = 1'b1;
    bus.i_rt = 7; bus.i_rs = 1; #1;
    chk("ba_stall", 32'(bus.o_stall), 1);
    tick(); idle_in(); #1;
    chk("ba_clear", 32'(bus.o_stall), 0);
    bus.i_rd_ex = 0; bus.i_we_ex = 1'b1; bus.i_branch = 1'b1; bus.i_rs = 0; #1;
    chk("r0_stall", 32'(bus.o_stall), 0);
    idle_in();

    // taken jump: flush, but not while a hazard is pending
    bus.i_jump_taken = 1'b1; #1;
    chk("j_flush", 32'(bus.o_flush_ifid), 1);
    tick(); idle_in(); #1;
    chk("j_fcnt", 32'(bus.o_flush_count), 1);
    bus.i_jump_taken = 1'b1; load_in_ex(5); bus.i_rs = 5; #1;
    chk("jh_flush", 32'(bus.o_flush_ifid), 0);
    chk("jh_stall", 32'(bus.o_stall), 1);
    tick(); idle_in(); #1;
    chk("jh_scnt", 32'(bus.o_stall_cycles), 5);

    // frozen in EXTRA
    load_in_ex(3); bus.i_rs = 3; bus.i_branch = 1'b1;
    tick(); idle_in(); bus.i_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1; chk("frz_stall", 32'(bus.o_stall), 1);
      chk("frz_scnt", 32'(bus.o_stall_cycles), 6);
      tick();
    end
    bus.i_valid = 1'b1; #1;
    chk("thaw_stall", 32'(bus.o_stall), 1);
    tick(); #1;
    chk("thaw_clear", 32'(bus.o_stall), 0);
    chk("thaw_scnt", 32'(bus.o_stall_cycles), 7);

    // reset in EXTRA
    load_in_ex(3); bus.i_rs = 3; bus.i_branch = 1'b1;
    tick(); idle_in(); rst = 1'b1;
    tick(); rst = 1'b0; #1;
    chk("rx_stall", 32'(bus.o_stall), 0);
    chk("rx_scnt", 32'(bus.o_stall_cycles), 0);
    chk("rx_fcnt", 32'(bus.o_flush_count), 0);

    // saturation
    load_in_ex(4); bus.i_rs = 4;
    for (int i = 0; i < CMAX + 6; i++) tick();
    chk("sat_scnt", 32'(bus.o_stall_cycles), 63);
    idle_in(); bus.i_jump_taken = 1'b1;
    for (int i = 0; i < CMAX + 6; i++) tick();
    chk("sat_fcnt", 32'(bus.o_flush_count), 63);
    idle_in(); rst = 1'b1; tick(); rst = 1'b0;

    // random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      bus.i_valid       = ($urandom_range(0, 7) != 0);
      bus.i_rs          = NA'($urandom_range(0, 3));
      bus.i_rt          = NA'($urandom_range(0, 3));
      bus.i_uses_rt     = 1'($urandom);
      bus.i_branch      = 1'($urandom);
      bus.i_jump_taken  = ($urandom_range(0, 3) == 0);
      bus.i_rd_ex       = NA'($urandom_range(0, 3));
      bus.i_we_ex       = 1'($urandom);
      bus.i_memread_ex  = 1'($urandom);
      bus.i_rd_mem      = NA'($urandom_range(0, 3));
      bus.i_memread_mem = 1'($urandom);
      rst               = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    idle_in();
    tick(); tick();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
